// File: rtl/serial_frame_transmitter.sv
// serial_frame_transmitter: parallel-to-serial frame sender for a downstream
// serial-load register. A word accepted on start && ready is emitted one bit
// per clock, and ctrl_output carries the shift code that makes the register
// rebuild the word in its original bit order.
module serial_frame_transmitter #(
  parameter int unsigned WIDTH                = 8,
  parameter logic [2:0]  CTRL_NONE            = 3'd0,
  parameter logic [2:0]  CTRL_SERIAL_MSB_LOAD = 3'd3,
  parameter logic [2:0]  CTRL_SERIAL_LSB_LOAD = 3'd4
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] parallel_data_input,
  input  logic             start,
  input  logic             lsb_first,
  output logic             ready,
  output logic             busy,
  output logic             serial_data_output,
  output logic [2:0]       ctrl_output,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_lsb;
  logic [CNT_W-1:0] r_cnt;

  // Frame FSM: the captured word is pre-shifted on accept so the first bit
  // is already on serial_data_output right after the accepting edge.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state            <= S_IDLE;
      r_shift            <= '0;
      r_lsb              <= 1'b0;
      r_cnt              <= '0;
      ready              <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      serial_data_output <= 1'b0;
      ctrl_output        <= CTRL_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready              <= 1'b1;
          busy               <= 1'b0;
          done               <= 1'b0;
          serial_data_output <= 1'b0;
          ctrl_output        <= CTRL_NONE;
          if (start) begin
            r_state <= S_SHIFT;
            ready   <= 1'b0;
            busy    <= 1'b1;
            r_lsb   <= lsb_first;
            r_cnt   <= CNT_W'(WIDTH - 1);
            if (lsb_first) begin
              // LSB first pairs with shift-right / insert-at-MSB downstream
              serial_data_output <= parallel_data_input[0];
              r_shift            <= parallel_data_input >> 1;
              ctrl_output        <= CTRL_SERIAL_MSB_LOAD;
            end else begin
              // MSB first pairs with shift-left / insert-at-LSB downstream
              serial_data_output <= parallel_data_input[WIDTH-1];
              r_shift            <= parallel_data_input << 1;
              ctrl_output        <= CTRL_SERIAL_LSB_LOAD;
            end
          end
        end

        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_state            <= S_DONE;
            done               <= 1'b1;
            serial_data_output <= 1'b0;
            ctrl_output        <= CTRL_NONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_lsb) begin
              serial_data_output <= r_shift[0];
              r_shift            <= r_shift >> 1;
            end else begin
              serial_data_output <= r_shift[WIDTH-1];
              r_shift            <= r_shift << 1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end

        default: begin
          r_state            <= S_IDLE;
          ready              <= 1'b1;
          busy               <= 1'b0;
          done               <= 1'b0;
          serial_data_output <= 1'b0;
          ctrl_output        <= CTRL_NONE;
        end
      endcase
    end
  end

endmodule
